// File: rtl/vram_scanout.sv
// Raster scanout for a 1bpp framebuffer: video timing, VRAM graphics-port fetch, 32-bit word serialiser.
// Optional `define PIXEL_DOUBLE_EN: half-resolution framebuffer, each pixel and line shown twice.
module vram_scanout #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        en_i,
   output logic [14:0] gb_adr_o,
   input  logic [31:0] gb_dat_i,
   output logic        pix_o,
   output logic        de_o,
   output logic        hs_o,
   output logic        vs_o,
   output logic        vblank_o,
   output logic        frame_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
`ifdef PIXEL_DOUBLE_EN
   localparam int WB = 6;
`else
   localparam int WB = 5;
`endif
   localparam int WP = 1 << WB;

   localparam logic [HW-1:0] HC_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HC_PRE    = HW'(H_TOTAL - 3);
   localparam logic [HW-1:0] HC_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HC_FLIM   = HW'(H_ACTIVE - 3);
   localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VC_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VC_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VC_ACT_M1 = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [WB-1:0] FETCH_PH  = WB'(WP - 3);

   logic [HW-1:0] r_hc;
   logic [VW-1:0] r_vc;
   logic          r_en;
   logic          r_boot;
   logic [31:0]   r_shift;
   logic [1:0]    r_fetch_dly;
   logic [14:0]   r_adr;
   logic          r_pix, r_de, r_hs, r_vs, r_vblank, r_frame;
`ifdef PIXEL_DOUBLE_EN
   logic [14:0]   r_line_start;
`endif

   logic          w_hc_wrap, w_vc_wrap, w_line_act, w_next_act, w_de;
   logic          w_fetch_in, w_fetch_pre, w_fetch, w_shift_en;
   logic [14:0]   w_adr_next;

   assign w_hc_wrap  = (r_hc == HC_LAST);
   assign w_vc_wrap  = (r_vc == VC_LAST);
   assign w_line_act = (r_vc < VC_ACT);
   assign w_next_act = w_vc_wrap || (r_vc < VC_ACT_M1);
   assign w_de       = (r_hc < HC_ACT) && w_line_act;

   // A fetch issued at hc lands in the shifter at the end of hc+2, just before its first pixel.
   assign w_fetch_in  = (r_hc[WB-1:0] == FETCH_PH) && (r_hc < HC_FLIM) && w_line_act;
   assign w_fetch_pre = (r_hc == HC_PRE) && w_next_act;
   assign w_fetch     = w_fetch_in || w_fetch_pre;

`ifdef PIXEL_DOUBLE_EN
   assign w_shift_en = r_hc[0];
`else
   assign w_shift_en = 1'b1;
`endif

   always_comb begin
      w_adr_next = r_adr;
      if (w_fetch_pre && w_vc_wrap)
         w_adr_next = '0;
`ifdef PIXEL_DOUBLE_EN
      // Odd raster lines replay the words of the even line above them.
      else if (w_fetch_pre && !r_vc[0])
         w_adr_next = r_line_start;
`endif
      else if (w_fetch)
         w_adr_next = r_adr + 15'd1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_hc         <= '0;
         r_vc         <= VC_LAST;
         r_en         <= 1'b0;
         r_boot       <= 1'b1;
         r_shift      <= '0;
         r_fetch_dly  <= '0;
         r_adr        <= '0;
         r_pix        <= 1'b0;
         r_de         <= 1'b0;
         r_hs         <= 1'b1;
         r_vs         <= 1'b1;
         r_vblank     <= 1'b1;
         r_frame      <= 1'b0;
`ifdef PIXEL_DOUBLE_EN
         r_line_start <= '0;
`endif
      end else begin
         r_hc <= w_hc_wrap ? '0 : r_hc + HW'(1);
         if (w_hc_wrap)
            r_vc <= w_vc_wrap ? '0 : r_vc + VW'(1);

         // The reset cycle itself stands in for the first latch point, so the first frame is black.
         r_boot <= 1'b0;
         if ((r_hc == '0) && w_vc_wrap && !r_boot)
            r_en <= en_i;

         r_fetch_dly <= {r_fetch_dly[0], w_fetch};
         r_adr       <= w_adr_next;
`ifdef PIXEL_DOUBLE_EN
         if (w_fetch_pre)
            r_line_start <= w_adr_next;
`endif

         if (r_fetch_dly[1])
            r_shift <= gb_dat_i;
         else if (w_shift_en)
            r_shift <= {r_shift[30:0], 1'b0};

         r_de     <= w_de;
         r_pix    <= w_de && r_en && r_shift[31];
         r_hs     <= !((r_hc >= HS_BEG) && (r_hc < HS_END));
         r_vs     <= !((r_vc >= VS_BEG) && (r_vc < VS_END));
         r_vblank <= !w_line_act;
         r_frame  <= (r_hc == '0) && (r_vc == VC_ACT);
      end
   end

   assign gb_adr_o = r_adr;
   assign pix_o    = r_pix;
   assign de_o     = r_de;
   assign hs_o     = r_hs;
   assign vs_o     = r_vs;
   assign vblank_o = r_vblank;
   assign frame_o  = r_frame;
endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout on an 80x8 raster (64x4 active) with a word-pattern VRAM model.
module tb_vram_scanout;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic [14:0] adr;
   logic [31:0] dat;
   logic        pix, de, hs, vs, vb, fr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int adr_max = 0;
   int adr_q[$];
   logic [14:0] adr_prev = '0;

   always #5 clk = ~clk;

   vram_scanout #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en),
      .gb_adr_o(adr), .gb_dat_i(dat),
      .pix_o(pix), .de_o(de), .hs_o(hs), .vs_o(vs),
      .vblank_o(vb), .frame_o(fr)
   );

   // VRAM graphics port: one-cycle read latency, word n = 80000001 ^ n
   always @(posedge clk) dat <= 32'h80000001 ^ {17'd0, adr};

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      if (!rst && (int'(adr) > adr_max)) adr_max <= int'(adr);
      if (!rst && (adr !== adr_prev)) adr_q.push_back(int'(adr));
      adr_prev <= adr;
   end

   task automatic chk(input string name, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @%0d: got %h expected %h", name, k, obs, exp);
      end
   endtask

   // Returns #1 after the k-th clock edge following reset release.
   task automatic goto(input int k);
      int n = 0;
      while ((cyc < k + 1) && (n < 100000)) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic chk_reset_state(input int k);
      chk("rst_pix", k, {31'd0, pix}, 32'd0);
      chk("rst_de", k, {31'd0, de}, 32'd0);
      chk("rst_hs", k, {31'd0, hs}, 32'd1);
      chk("rst_vs", k, {31'd0, vs}, 32'd1);
      chk("rst_vblank", k, {31'd0, vb}, 32'd1);
      chk("rst_frame", k, {31'd0, fr}, 32'd0);
      chk("rst_adr", k, {17'd0, adr}, 32'd0);
   endtask

   // base = output cycle showing hc=0, vc=0; optionally changes en_i at index en_idx.
   task automatic check_frame(input int base, input bit data, input int en_idx, input logic en_val);
      int h, v, w, de_cnt;
      logic [31:0] wv;
      logic e_de, e_pix;
      de_cnt = 0;
      for (int idx = 0; idx < 640; idx++) begin
         goto(base + idx);
         h = idx % 80;
         v = idx / 80;
         e_de = (h < 64) && (v < 4);
         w = v * 2 + h / 32;
         wv = 32'h80000001 ^ 32'(w);
         e_pix = data && e_de && wv[31 - (h % 32)];
         if (de === 1'b1) de_cnt++;
         chk("de", base + idx, {31'd0, de}, {31'd0, e_de});
         chk("pix", base + idx, {31'd0, pix}, {31'd0, e_pix});
         chk("hs", base + idx, {31'd0, hs}, {31'd0, !((h >= 68) && (h < 76))});
         chk("vs", base + idx, {31'd0, vs}, {31'd0, !((v >= 5) && (v < 7))});
         chk("vblank", base + idx, {31'd0, vb}, {31'd0, v >= 4});
         chk("frame", base + idx, {31'd0, fr}, {31'd0, (h == 0) && (v == 4)});
         if (idx == en_idx) en = en_val;
      end
      chk("de_per_frame", base, 32'(de_cnt), 32'd256);
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state(-1);
      rst = 1'b0;

      // One blank prefetch line, then a black first frame even though en_i is high
      goto(79);
      chk("de_before_first_line", 79, {31'd0, de}, 32'd0);
      check_frame(80, 1'b0, -1, 1'b1);

      // Frame with data; en_i drops mid-frame without effect here
      check_frame(720, 1'b1, 100, 1'b0);
      // Latched 0: black frame, timing unchanged; en_i raised mid-frame
      check_frame(1360, 1'b0, 40, 1'b1);
      check_frame(2000, 1'b1, -1, 1'b1);

      chk("adr_max", 2640, 32'(adr_max), 32'd7);
      chk("adr_changes", 2640, 32'(adr_q.size() >= 24), 32'd1);
      for (int i = 0; i < 24; i++)
         if (i < adr_q.size())
            chk("adr_seq", i, 32'(adr_q[i]), 32'((i + 1) % 8));

      // Reset sampled while counters are at hc=30, vc=2 of the next frame
      goto(2640 + 190 - 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state(2830);
      rst = 1'b0;
      for (int k = 0; k < 80; k++) begin
         goto(k);
         chk("de_blank_after_reset", k, {31'd0, de}, 32'd0);
      end
      check_frame(80, 1'b0, -1, 1'b1);
      chk("adr_max_final", 720, 32'(adr_max), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
